pipelined_inst_sequencer: RTL and testbench



---
 rtl/pipelined_inst_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pipelined_inst_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_inst_sequencer.sv
// Pipelined instruction sequencer: queues instruction words in a FIFO and issues one buffer request
// per cycle, delaying PE opcodes to line up with buffer data. Optional issue stall: CONTROLLER_STALL_EN.
`ifndef CONTROLLER_COUNT_BITWIDTH
`define CONTROLLER_COUNT_BITWIDTH 8
`endif
`ifndef CONTROLLER_MEMA_INC_BITWIDTH
`define CONTROLLER_MEMA_INC_BITWIDTH 4
`endif
`ifndef CONTROLLER_MEMB_INC_BITWIDTH
`define CONTROLLER_MEMB_INC_BITWIDTH 4
`endif

package pipelined_inst_sequencer_pkg;
  localparam int COUNT_BW    = `CONTROLLER_COUNT_BITWIDTH;
  localparam int MEMA_INC_BW = `CONTROLLER_MEMA_INC_BITWIDTH;
  localparam int MEMB_INC_BW = `CONTROLLER_MEMB_INC_BITWIDTH;
  localparam int MEMA_OFF_W  = 8;
  localparam int MEMB_OFF_W  = 8;
  localparam int PE_OP_W     = 8;

  typedef struct packed {
    logic [MEMA_OFF_W-1:0] mema_offset;
    logic [MEMB_OFF_W-1:0] memb_offset;
  } buf_inst_t;

  typedef struct packed {
    logic [PE_OP_W-1:0] op;
  } pe_inst_t;

  typedef struct packed {
    buf_inst_t              buf_inst;
    pe_inst_t               pe_inst;
    logic [COUNT_BW-1:0]    count;
    logic [MEMA_INC_BW-1:0] mema_inc;
    logic [MEMB_INC_BW-1:0] memb_inc;
  } instruction_t;
endpackage

module pipelined_inst_sequencer
  import pipelined_inst_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BUF_LATENCY = 1,
  parameter int COUNT_W     = `CONTROLLER_COUNT_BITWIDTH,
  parameter int MEMA_INC_W  = `CONTROLLER_MEMA_INC_BITWIDTH,
  parameter int MEMB_INC_W  = `CONTROLLER_MEMB_INC_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  instruction_t                inst,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  output logic                        inst_exec_begins,
  output logic                        inst_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output buf_inst_t                   buf_inst,
  output logic                        buf_inst_valid,
  output pe_inst_t                    pe_inst,
  output logic                        pe_inst_valid,
`ifdef CONTROLLER_STALL_EN
  input  logic                        issue_stall,
`endif
  output logic                        dbg_state
);
  // Handshake: a push happens on a posedge where inst_valid && inst_ready; inst_ready depends only
  // on the level register, and buffer/PE outputs are qualified by their *_valid strobes.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int NSTG  = BUF_LATENCY + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  logic stall;
`ifdef CONTROLLER_STALL_EN
  assign stall = issue_stall;
`else
  assign stall = 1'b0;
`endif

  instruction_t           fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       level_q, level_d;
  instruction_t           head;
  logic                   push, pop, fifo_ne;

  state_e                 state_q;
  buf_inst_t              buf_q;
  logic                   buf_valid_q, begins_q;
  pe_inst_t               cur_pe_q;
  logic [COUNT_W-1:0]     count_q, iter_q;
  logic [MEMA_INC_W-1:0]  mema_inc_q;
  logic [MEMB_INC_W-1:0]  memb_inc_q;
  logic                   at_last;

  logic [NSTG-1:0]        pv_q, pl_q;
  pe_inst_t               pd_q [NSTG];

  assign head       = fifo_mem_q[rd_ptr_q];
  assign fifo_ne    = (level_q != '0);
  assign inst_ready = (level_q != LVL_W'(FIFO_DEPTH));
  assign push       = inst_valid && inst_ready;
  assign at_last    = (iter_q == count_q);
  // Pop only from the registered level, so a word is never consumed in the cycle it arrives.
  assign pop        = fifo_ne && !stall && ((state_q == IDLE) || at_last);
  assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= inst;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      begins_q    <= 1'b0;
      cur_pe_q    <= '0;
      count_q     <= '0;
      iter_q      <= '0;
      mema_inc_q  <= '0;
      memb_inc_q  <= '0;
    end else if (pop) begin
      // Covers both the IDLE start and the zero-bubble hand-off at the last iteration.
      state_q     <= RUN;
      buf_q       <= head.buf_inst;
      cur_pe_q    <= head.pe_inst;
      count_q     <= COUNT_W'(head.count);
      mema_inc_q  <= MEMA_INC_W'(head.mema_inc);
      memb_inc_q  <= MEMB_INC_W'(head.memb_inc);
      iter_q      <= '0;
      buf_valid_q <= 1'b1;
      begins_q    <= 1'b1;
    end else if (state_q == RUN && !stall) begin
      if (!at_last) begin
        iter_q            <= iter_q + COUNT_W'(1);
        buf_q.mema_offset <= buf_q.mema_offset + MEMA_OFF_W'(mema_inc_q);
        buf_q.memb_offset <= buf_q.memb_offset + MEMB_OFF_W'(memb_inc_q);
        begins_q          <= 1'b0;
      end else begin
        state_q     <= IDLE;
        buf_valid_q <= 1'b0;
        begins_q    <= 1'b0;
      end
    end
  end

  assign buf_inst         = buf_q;
  assign buf_inst_valid   = buf_valid_q && !stall;
  assign inst_exec_begins = begins_q && !stall;

  // Opcode data only advances behind a valid entry, so pe_inst holds between instructions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < NSTG; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= buf_inst_valid;
      pl_q[0] <= at_last;
      if (buf_inst_valid) pd_q[0] <= cur_pe_q;
      for (int i = 1; i < NSTG; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign pe_inst       = pd_q[NSTG-1];
  assign pe_inst_valid = pv_q[NSTG-1];
  assign inst_done     = pv_q[NSTG-1] && pl_q[NSTG-1];
  assign busy          = fifo_ne || (state_q == RUN) || (|pv_q);
  assign fifo_level    = level_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_pipelined_inst_sequencer.sv
// Self-checking bench for pipelined_inst_sequencer: directed timing scenarios plus randomized
// traffic scored against an instruction-expansion reference model.
module tb_pipelined_inst_sequencer;
  import pipelined_inst_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int BW    = 1 + $bits(buf_inst_t);
  localparam int PW    = 1 + $bits(pe_inst_t);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  instruction_t         inst = '0;
  logic                 inst_valid = 1'b0;
  logic                 inst_ready, inst_exec_begins, inst_done, busy;
  logic [LVL_W-1:0]     fifo_level;
  buf_inst_t            buf_inst;
  logic                 buf_inst_valid;
  pe_inst_t             pe_inst;
  logic                 pe_inst_valid;
  logic                 dbg_state;
`ifdef CONTROLLER_STALL_EN
  logic                 issue_stall = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [BW-1:0] exp_q[$];
  logic [PW-1:0] exp_pe_q[$];
  int            issue_cyc_q[$];

  pipelined_inst_sequencer #(.FIFO_DEPTH(DEPTH), .BUF_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_exec_begins(inst_exec_begins), .inst_done(inst_done), .busy(busy),
    .fifo_level(fifo_level), .buf_inst(buf_inst), .buf_inst_valid(buf_inst_valid),
    .pe_inst(pe_inst), .pe_inst_valid(pe_inst_valid),
`ifdef CONTROLLER_STALL_EN
    .issue_stall(issue_stall),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (checks=%0d)", checks);
    $fatal(1);
  end

  function automatic instruction_t mk(input int ma, input int mb, input int ia, input int ib,
                                      input int cnt, input int op);
    instruction_t w;
    w.buf_inst.mema_offset = MEMA_OFF_W'(ma);
    w.buf_inst.memb_offset = MEMB_OFF_W'(mb);
    w.pe_inst.op           = PE_OP_W'(op);
    w.count                = COUNT_BW'(cnt);
    w.mema_inc             = MEMA_INC_BW'(ia);
    w.memb_inc             = MEMB_INC_BW'(ib);
    return w;
  endfunction

  // Scoreboard: each accepted instruction expands into count+1 issues with arithmetic offsets.
  always @(negedge clk) begin
    logic [BW-1:0] e_b;
    logic [PW-1:0] e_p;
    int ic;
    if (mon_en) begin
      if (inst_valid && inst_ready) begin
        for (int k = 0; k <= int'(inst.count); k++) begin
          e_b = {k == 0,
                 MEMA_OFF_W'((int'(inst.buf_inst.mema_offset) + k * int'(inst.mema_inc)) % (1 << MEMA_OFF_W)),
                 MEMB_OFF_W'((int'(inst.buf_inst.memb_offset) + k * int'(inst.memb_inc)) % (1 << MEMB_OFF_W))};
          e_p = {k == int'(inst.count), inst.pe_inst};
          exp_q.push_back(e_b);
          exp_pe_q.push_back(e_p);
        end
      end
      checks++;
      if (buf_inst_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_issue: got %h, none expected", {inst_exec_begins, buf_inst});
        end else begin
          e_b = exp_q.pop_front();
          if ({inst_exec_begins, buf_inst} !== e_b) begin
            errors++;
            $display("FAIL sb_issue: got %h expected %h", {inst_exec_begins, buf_inst}, e_b);
          end
        end
        issue_cyc_q.push_back(cyc);
      end else if (inst_exec_begins !== 1'b0) begin
        errors++;
        $display("FAIL sb_begins_idle: got %b expected 0", inst_exec_begins);
      end
      checks++;
      if (pe_inst_valid) begin
        if (exp_pe_q.size() == 0 || issue_cyc_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pe: got %h, none expected", {inst_done, pe_inst});
        end else begin
          e_p = exp_pe_q.pop_front();
          ic  = issue_cyc_q.pop_front();
          if ({inst_done, pe_inst} !== e_p || (cyc - ic) != LAT + 1) begin
            errors++;
            $display("FAIL sb_pe: got %h lat %0d expected %h lat %0d", {inst_done, pe_inst}, cyc - ic, e_p, LAT + 1);
          end
        end
      end else if (inst_done !== 1'b0) begin
        errors++;
        $display("FAIL sb_done_idle: got %b expected 0", inst_done);
      end
    end
  end

  // Driver: hold the word until accepted (bounded)
  task automatic push_inst(input instruction_t w);
    bit ok;
    ok = 1'b0;
    inst = w;
    inst_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inst_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL push_timeout: ready 0 expected 1"); end
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && exp_pe_q.size() == 0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d busy %b level %0d expected 0/0 0 0",
               exp_q.size(), exp_pe_q.size(), busy, fifo_level);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (inst_ready !== 1'b1 || fifo_level !== '0 || buf_inst_valid !== 1'b0 || pe_inst_valid !== 1'b0 ||
        inst_exec_begins !== 1'b0 || inst_done !== 1'b0 || busy !== 1'b0 || buf_inst !== '0 ||
        pe_inst !== '0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy %b lvl %0d bv %b pv %b beg %b done %b busy %b buf %h pe %h st %b expected rdy 1, rest 0",
               inst_ready, fifo_level, buf_inst_valid, pe_inst_valid, inst_exec_begins, inst_done, busy,
               buf_inst, pe_inst, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit bv, pv, dn, bg;
    push_inst(mk(10, 0, 2, 0, 3, 8'h5a));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bv = (k >= 2 && k <= 5);
      pv = (k >= 4 && k <= 7);
      dn = (k == 7);
      bg = (k == 2);
      checks++;
      if (buf_inst_valid !== bv || pe_inst_valid !== pv || inst_done !== dn || inst_exec_begins !== bg ||
          (bv && buf_inst.mema_offset !== MEMA_OFF_W'(10 + 2 * (k - 2))) || (pv && pe_inst.op !== 8'h5a)) begin
        errors++;
        $display("FAIL single_c%0d: bv %b pv %b done %b beg %b mema %0d pe %h expected %b %b %b %b %0d 5a",
                 k, buf_inst_valid, pe_inst_valid, inst_done, inst_exec_begins, buf_inst.mema_offset, pe_inst.op,
                 bv, pv, dn, bg, bv ? 10 + 2 * (k - 2) : 0);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n, first, last;
    logic [3:0] bpat;
    n = 0; first = 0; last = 0; bpat = '0;
    push_inst(mk(40, 0, 1, 0, 1, 8'h01));
    push_inst(mk(80, 0, 1, 0, 1, 8'h02));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (buf_inst_valid) begin
        if (n == 0) first = cyc;
        last = cyc;
        if (n < 4) bpat[n] = inst_exec_begins;
        n++;
      end
    end
    checks++;
    if (n != 4 || last - first != 3 || bpat !== 4'b0101) begin
      errors++;
      $display("FAIL back_to_back: issues %0d span %0d begins %b expected 4 3 0101", n, last - first, bpat);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    bit acc;
    acc = 1'b0;
    push_inst(mk(0, 0, 1, 1, 15, 8'h11));
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) push_inst(mk(100 + i * 10, i, 1, 1, 2, 8'h20 + i));
    @(negedge clk);
    checks++;
    if (fifo_level !== LVL_W'(4) || inst_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: level %0d ready %b expected 4 0", fifo_level, inst_ready);
    end
    @(posedge clk); #1;
    inst = mk(200, 7, 1, 1, 0, 8'h30);
    inst_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_ready) begin
        acc = 1'b1;
        checks++;
        if (inst_exec_begins !== 1'b1 || buf_inst.mema_offset !== 8'd100 || fifo_level !== LVL_W'(3)) begin
          errors++;
          $display("FAIL fifth_push: begins %b mema %0d level %0d expected 1 100 3",
                   inst_exec_begins, buf_inst.mema_offset, fifo_level);
        end
        break;
      end
      checks++;
      if (fifo_level !== LVL_W'(4)) begin
        errors++;
        $display("FAIL full_hold: level %0d expected 4", fifo_level);
      end
    end
    checks++;
    if (!acc) begin errors++; $display("FAIL fifth_push_timeout: accepted 0 expected 1"); end
    @(posedge clk); #1;
    inst_valid = 1'b0;
    drain();
  endtask

  task automatic test_wrap();
    int n;
    logic [MEMB_OFF_W-1:0] mb [2];
    n = 0;
    mb[0] = '0; mb[1] = '0;
    push_inst(mk(0, (1 << MEMB_OFF_W) - 2, 0, 3, 1, 8'h77));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (buf_inst_valid) begin
        if (n < 2) mb[n] = buf_inst.memb_offset;
        n++;
      end
    end
    checks++;
    if (n != 2 || mb[0] !== MEMB_OFF_W'((1 << MEMB_OFF_W) - 2) || mb[1] !== MEMB_OFF_W'(1)) begin
      errors++;
      $display("FAIL wrap: issues %0d memb %0d,%0d expected 2 %0d,1", n, mb[0], mb[1], (1 << MEMB_OFF_W) - 2);
    end
    drain();
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 14; i++) begin
      push_inst(mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 255)));
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
    drain();
  endtask

  task automatic test_mid_reset();
    bit ok;
    ok = 1'b0;
    mon_en = 1'b0;
    push_inst(mk(5, 5, 1, 1, 5, 8'h40));
    push_inst(mk(9, 9, 1, 1, 3, 8'h41));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pe_inst_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || fifo_level !== LVL_W'(1)) begin
      errors++;
      $display("FAIL mid_reset_setup: pe_valid_seen %b level %0d expected 1 1", ok, fifo_level);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (buf_inst_valid !== 1'b0 || pe_inst_valid !== 1'b0 || inst_done !== 1'b0 || inst_exec_begins !== 1'b0 ||
          fifo_level !== '0 || inst_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_c%0d: bv %b pv %b done %b beg %b lvl %0d rdy %b busy %b expected 0 0 0 0 0 1 0",
                 k, buf_inst_valid, pe_inst_valid, inst_done, inst_exec_begins, fifo_level, inst_ready, busy);
      end
    end
    exp_q.delete();
    exp_pe_q.delete();
    issue_cyc_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef CONTROLLER_STALL_EN
  task automatic test_stall();
    bit bv, pv, dn;
    int ma;
    push_inst(mk(20, 0, 1, 0, 2, 8'h66));
    for (int k = 1; k <= 10; k++) begin
      issue_stall = (k >= 3 && k <= 5);
      @(negedge clk);
      bv = (k == 2 || k == 6 || k == 7);
      pv = (k == 4 || k == 8 || k == 9);
      dn = (k == 9);
      ma = (k == 2) ? 20 : (k == 6) ? 21 : 22;
      checks++;
      if (buf_inst_valid !== bv || pe_inst_valid !== pv || inst_done !== dn ||
          (bv && buf_inst.mema_offset !== MEMA_OFF_W'(ma))) begin
        errors++;
        $display("FAIL stall_c%0d: bv %b pv %b done %b mema %0d expected %b %b %b %0d",
                 k, buf_inst_valid, pe_inst_valid, inst_done, buf_inst.mema_offset, bv, pv, dn, ma);
      end
      @(posedge clk); #1;
    end
    issue_stall = 1'b0;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_wrap();
    test_random();
    test_mid_reset();
`ifdef CONTROLLER_STALL_EN
    test_stall();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
